// File: rtl/spi_arbiter_pkg.sv
//------------------------------------------------------------------------------
// spi_arbiter_pkg: shared FSM encoding and default timeout for spi_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_arbiter_pkg;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_START = C_ST_START,
        ST_WAIT  = C_ST_WAIT,
        ST_HOLD  = C_ST_HOLD
    } state_t;

    localparam logic [15:0] C_TIMEOUT_DEFAULT = 16'd1024;

endpackage

`default_nettype wire

// File: rtl/spi_rr_pick.sv
//------------------------------------------------------------------------------
// spi_rr_pick: two-requester round-robin selector; PTR names the tie winner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_rr_pick (
    input  logic [1:0] REQ,
    input  logic       PTR,
    output logic [1:0] PICK
);

    always_comb begin
        PICK    = 2'b00;
        PICK[1] = REQ[1] & (~REQ[0] | PTR);
        PICK[0] = REQ[0] & (~REQ[1] | ~PTR);
    end

endmodule

`default_nettype wire

// File: rtl/spi_arbiter.sv
//------------------------------------------------------------------------------
// spi_arbiter: grants a shared SPI master to one of two burst requesters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = C_TIMEOUT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [1:0] REQ,
    input  logic [1:0] LAST,
    input  logic [7:0] TXD0,
    input  logic [7:0] TXD1,
    output logic [1:0] GNT,
    output logic [1:0] BYTE_ACK,
    output logic [7:0] RXD,
    output logic       SPI_START,
    output logic [7:0] SPI_TXD,
    input  logic       SPI_DONE,
    input  logic [7:0] SPI_RXD,
    output logic       TIMEOUT_IRQ,
    output logic       BUSY
);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  ack_q, ack_d;
    logic        start_q, start_d;
    logic [7:0]  txd_q, txd_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        irq_q, irq_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        done_q;

    logic [1:0]  w_pick;
    logic        w_owner;
    logic        w_done_rise;

    spi_rr_pick u_pick (
        .REQ  (REQ),
        .PTR  (ptr_q),
        .PICK (w_pick)
    );

    // Owner index is implied by the one-hot grant while a burst is active.
    assign w_owner     = gnt_q[1];
    assign w_done_rise = SPI_DONE & ~done_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        ack_d   = 2'b00;
        start_d = 1'b0;
        txd_d   = txd_q;
        rxd_d   = rxd_q;
        irq_d   = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    gnt_d   = w_pick;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!REQ[w_owner]) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    start_d = 1'b1;
                    txd_d   = w_owner ? TXD1 : TXD0;
                    last_d  = LAST[w_owner];
                    cnt_d   = 16'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the timeout cycle still counts as a byte.
                if (w_done_rise) begin
                    rxd_d   = SPI_RXD;
                    ack_d   = gnt_q;
                    state_d = ST_HOLD;
                end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                    irq_d   = 1'b1;
                    gnt_d   = 2'b00;
                    ptr_d   = ~w_owner;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (last_q) begin
                    gnt_d   = 2'b00;
                    ptr_d   = ~w_owner;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_START;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b0;
            ack_q   <= 2'b00;
            start_q <= 1'b0;
            txd_q   <= 8'h00;
            rxd_q   <= 8'h00;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 16'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            txd_q   <= txd_d;
            rxd_q   <= rxd_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= SPI_DONE;
        end
    end

    assign GNT         = gnt_q;
    assign BYTE_ACK    = ack_q;
    assign RXD         = rxd_q;
    assign SPI_START   = start_q;
    assign SPI_TXD     = txd_q;
    assign TIMEOUT_IRQ = irq_q;
    assign BUSY        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
//------------------------------------------------------------------------------
// tb_spi_arbiter: directed self-checking bench for spi_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_arbiter;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [1:0] REQ = 2'b00;
    logic [1:0] LAST = 2'b00;
    logic [7:0] TXD0 = 8'h00;
    logic [7:0] TXD1 = 8'h00;
    logic       SPI_DONE = 1'b0;
    logic [7:0] SPI_RXD = 8'h00;

    logic [1:0] GNT, BYTE_ACK;
    logic [7:0] RXD, SPI_TXD;
    logic       SPI_START, TIMEOUT_IRQ, BUSY;

    logic [1:0] b_GNT, b_BYTE_ACK;
    logic [7:0] b_RXD, b_SPI_TXD;
    logic       b_SPI_START, b_TIMEOUT_IRQ, b_BUSY;

    int n_chk = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_ack0 = 0;
    int n_ack1 = 0;
    int n_irq = 0;

    always #5 CLK = ~CLK;

    // Short-timeout instance used for most scenarios.
    spi_arbiter #(.TIMEOUT_CYC(16'd16)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .LAST(LAST), .TXD0(TXD0), .TXD1(TXD1),
        .GNT(GNT), .BYTE_ACK(BYTE_ACK), .RXD(RXD), .SPI_START(SPI_START),
        .SPI_TXD(SPI_TXD), .SPI_DONE(SPI_DONE), .SPI_RXD(SPI_RXD),
        .TIMEOUT_IRQ(TIMEOUT_IRQ), .BUSY(BUSY)
    );

    // Default-timeout instance for the slow single-byte transfer.
    spi_arbiter u_big (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .LAST(LAST), .TXD0(TXD0), .TXD1(TXD1),
        .GNT(b_GNT), .BYTE_ACK(b_BYTE_ACK), .RXD(b_RXD), .SPI_START(b_SPI_START),
        .SPI_TXD(b_SPI_TXD), .SPI_DONE(SPI_DONE), .SPI_RXD(SPI_RXD),
        .TIMEOUT_IRQ(b_TIMEOUT_IRQ), .BUSY(b_BUSY)
    );

    always @(posedge CLK) begin
        if (SPI_START)   n_start = n_start + 1;
        if (BYTE_ACK[0]) n_ack0  = n_ack0 + 1;
        if (BYTE_ACK[1]) n_ack1  = n_ack1 + 1;
        if (TIMEOUT_IRQ) n_irq   = n_irq + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; REQ = 2'b00; LAST = 2'b00; SPI_DONE = 1'b0; SPI_RXD = 8'h00;
        tick(); tick();
        RSTn = 1'b1;
        tick();
        n_start = 0; n_ack0 = 0; n_ack1 = 0; n_irq = 0;
    endtask

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = SPI_START;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int n;
        bit hit;

        // Reset state
        tick(); tick();
        check("rst_gnt", {30'd0, GNT}, 32'd0);
        check("rst_ack", {30'd0, BYTE_ACK}, 32'd0);
        check("rst_start", {31'd0, SPI_START}, 32'd0);
        check("rst_txd", {24'd0, SPI_TXD}, 32'd0);
        check("rst_rxd", {24'd0, RXD}, 32'd0);
        check("rst_irq", {31'd0, TIMEOUT_IRQ}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        RSTn = 1'b1;
        tick();

        // Single byte, SPI_DONE 20 cycles after start (default timeout)
        do_reset();
        REQ = 2'b01; LAST = 2'b01; TXD0 = 8'hA5;
        tick();
        check("sb_gnt_lat", {30'd0, b_GNT}, 32'h1);
        check("sb_no_early_start", {31'd0, b_SPI_START}, 32'd0);
        tick();
        check("sb_start", {31'd0, b_SPI_START}, 32'd1);
        check("sb_txd", {24'd0, b_SPI_TXD}, 32'hA5);
        repeat (19) tick();
        SPI_DONE = 1'b1; SPI_RXD = 8'h3C;
        tick();
        check("sb_ack", {30'd0, b_BYTE_ACK}, 32'h1);
        check("sb_rxd", {24'd0, b_RXD}, 32'h3C);
        SPI_DONE = 1'b0; SPI_RXD = 8'h00; REQ = 2'b00;
        tick();
        check("sb_ack_once", {30'd0, b_BYTE_ACK}, 32'd0);
        check("sb_gnt_clr", {30'd0, b_GNT}, 32'd0);
        check("sb_busy_clr", {31'd0, b_BUSY}, 32'd0);
        check("sb_txd_held", {24'd0, b_SPI_TXD}, 32'hA5);
        check("sb_rxd_held", {24'd0, b_RXD}, 32'h3C);
        REQ = 2'b11;
        tick();
        check("sb_ptr1", {30'd0, b_GNT}, 32'h2);
        REQ = 2'b00;

        // Contention from reset
        do_reset();
        REQ = 2'b11; LAST = 2'b11; TXD0 = 8'h11; TXD1 = 8'h22;
        tick();
        check("ct_gnt0", {30'd0, GNT}, 32'h1);
        tick();
        check("ct_txd0", {24'd0, SPI_TXD}, 32'h11);
        tick();
        SPI_DONE = 1'b1; SPI_RXD = 8'h55;
        tick();
        check("ct_ack0", {30'd0, BYTE_ACK}, 32'h1);
        check("ct_rxd0", {24'd0, RXD}, 32'h55);
        SPI_DONE = 1'b0; REQ = 2'b10;
        tick();
        check("ct_rel0", {30'd0, GNT}, 32'd0);
        tick();
        check("ct_gnt1", {30'd0, GNT}, 32'h2);
        tick();
        check("ct_start1", {31'd0, SPI_START}, 32'd1);
        check("ct_txd1", {24'd0, SPI_TXD}, 32'h22);
        SPI_DONE = 1'b1; SPI_RXD = 8'h66;
        tick();
        check("ct_ack1", {30'd0, BYTE_ACK}, 32'h2);
        SPI_DONE = 1'b0; REQ = 2'b00;
        tick();
        check("ct_rel1", {30'd0, GNT}, 32'd0);
        REQ = 2'b11;
        tick();
        check("ct_ptr0", {30'd0, GNT}, 32'h1);
        REQ = 2'b00;
        tick();
        check("ct_start_drop", {30'd0, GNT}, 32'd0);
        check("ct_no_start", {31'd0, SPI_START}, 32'd0);
        tick();
        check("ct_nstart", n_start, 32'd2);

        // Three-byte burst from requester 1 with multi-cycle SPI_DONE
        do_reset();
        REQ = 2'b10; LAST = 2'b00; TXD1 = 8'hB0;
        for (int b = 0; b < 3; b++) begin
            wait_start("bu_start_seen");
            check("bu_txd", {24'd0, SPI_TXD}, 32'hB0 + b);
            check("bu_gnt", {30'd0, GNT}, 32'h2);
            tick(); tick();
            SPI_DONE = 1'b1; SPI_RXD = 8'hC0 + b[7:0];
            tick();
            check("bu_ack", {30'd0, BYTE_ACK}, 32'h2);
            check("bu_gnt_hold", {30'd0, GNT}, 32'h2);
            TXD1 = 8'hB1 + b[7:0];
            if (b == 1) LAST = 2'b10;
            if (b == 2) REQ = 2'b00;
            tick();
            SPI_DONE = 1'b0;
        end
        repeat (4) tick();
        check("bu_gnt_end", {30'd0, GNT}, 32'd0);
        check("bu_nstart", n_start, 32'd3);
        check("bu_nack1", n_ack1, 32'd3);
        check("bu_rxd", {24'd0, RXD}, 32'hC2);

        // Timeout with TIMEOUT_CYC=16
        do_reset();
        REQ = 2'b01; LAST = 2'b01; TXD0 = 8'h77;
        wait_start("to_start_seen");
        n = 0; hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            n = n + 1;
            hit = TIMEOUT_IRQ;
        end
        check("to_irq_seen", {31'd0, hit}, 32'd1);
        check("to_latency", n, 32'd16);
        check("to_gnt", {30'd0, GNT}, 32'd0);
        REQ = 2'b00;
        tick();
        check("to_irq_pulse", {31'd0, TIMEOUT_IRQ}, 32'd0);
        check("to_no_ack", n_ack0, 32'd0);

        // REQ0 dropped during WAIT
        do_reset();
        REQ = 2'b01; LAST = 2'b00; TXD0 = 8'h5A;
        wait_start("dr_start_seen");
        REQ = 2'b00;
        tick(); tick();
        SPI_DONE = 1'b1; SPI_RXD = 8'h99;
        tick();
        check("dr_ack", {30'd0, BYTE_ACK}, 32'h1);
        SPI_DONE = 1'b0;
        tick(); tick();
        check("dr_gnt", {30'd0, GNT}, 32'd0);
        tick();
        check("dr_nstart", n_start, 32'd1);

        // Reset asserted during WAIT
        do_reset();
        REQ = 2'b01; LAST = 2'b01; TXD0 = 8'hE1;
        wait_start("rw_start_seen");
        tick();
        RSTn = 1'b0;
        #1;
        check("rw_gnt", {30'd0, GNT}, 32'd0);
        check("rw_busy", {31'd0, BUSY}, 32'd0);
        check("rw_txd", {24'd0, SPI_TXD}, 32'd0);
        REQ = 2'b00;
        tick(); tick();
        RSTn = 1'b1;
        tick();
        SPI_DONE = 1'b1; SPI_RXD = 8'h44;
        tick();
        SPI_DONE = 1'b0;
        repeat (3) tick();
        check("rw_no_ack", n_ack0, 32'd0);
        check("rw_rxd", {24'd0, RXD}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
